// File: rtl/led_reg_arbiter.sv
// Arbitrates the LED-driver register-file port between buffered I2C-host writes
// and an internal req/gnt requester, with a fairness cap on consecutive host grants.
module led_reg_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_GRANT  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          host_wr_en,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_data,
  input  logic                          ovf_clr,
  output logic                          host_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          int_req,
  input  logic                          int_we,
  input  logic [ADDR_W-1:0]             int_addr,
  input  logic [DATA_W-1:0]             int_wdata,
  output logic                          int_gnt,
  output logic                          int_rvalid,
  output logic [DATA_W-1:0]             int_rdata,
  output logic [ADDR_W-1:0]             reg_addr,
  output logic [DATA_W-1:0]             reg_wdata,
  output logic                          reg_we,
  output logic                          reg_re,
  input  logic [DATA_W-1:0]             reg_rdata
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STREAK_W = $clog2(MAX_GRANT + 1);
  localparam logic [CNT_W-1:0]    COUNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_GRANT);

  localparam logic [0:0] ARB_ISSUE  = 1'b0;
  localparam logic [0:0] ARB_RDWAIT = 1'b1;

  logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [STREAK_W-1:0]      streak;
  logic [0:0]               state;

  logic fifo_empty;
  logic fifo_full;
  logic int_req_v;
  logic sel_host;
  logic sel_int;
  logic enq;
  logic drop;

  // The grant cycle still sees int_req high; that is the old request, not a new one.
  assign int_req_v  = int_req & ~int_gnt;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == COUNT_FULL);
  assign sel_host   = enable && (state == ARB_ISSUE) && !fifo_empty &&
                      (!int_req_v || (streak < STREAK_MAX));
  assign sel_int    = enable && (state == ARB_ISSUE) && !sel_host && int_req_v;
  assign enq        = host_wr_en && (!fifo_full || sel_host);
  assign drop       = host_wr_en && fifo_full && !sel_host;

  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= {host_addr, host_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      host_overflow <= 1'b0;
      streak        <= '0;
      state         <= ARB_ISSUE;
      int_gnt       <= 1'b0;
      int_rvalid    <= 1'b0;
      int_rdata     <= '0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      reg_we        <= 1'b0;
      reg_re        <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (sel_host) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !sel_host) fifo_count <= fifo_count + CNT_W'(1);
      else if (!enq && sel_host) fifo_count <= fifo_count - CNT_W'(1);

      if (drop) host_overflow <= 1'b1;
      else if (ovf_clr) host_overflow <= 1'b0;

      if (!int_req || sel_int) streak <= '0;
      else if (sel_host && int_req_v) streak <= streak + STREAK_W'(1);

      int_gnt    <= 1'b0;
      int_rvalid <= 1'b0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;

      if (sel_host) begin
        reg_we    <= 1'b1;
        reg_addr  <= fifo_mem[rd_ptr][ADDR_W+DATA_W-1:DATA_W];
        reg_wdata <= fifo_mem[rd_ptr][DATA_W-1:0];
      end

      if (sel_int) begin
        int_gnt   <= 1'b1;
        reg_we    <= int_we;
        reg_re    <= !int_we;
        reg_addr  <= int_addr;
        reg_wdata <= int_wdata;
        if (!int_we) state <= ARB_RDWAIT;
      end

      // reg_re still high means the register file has not answered yet.
      if (state == ARB_RDWAIT && !reg_re) begin
        int_rdata  <= reg_rdata;
        int_rvalid <= 1'b1;
        state      <= ARB_ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_led_reg_arbiter.sv
// Scoreboard bench for led_reg_arbiter: expected bus transactions and read data
// are queued as stimulus is driven and popped as the DUT produces them.
module tb_led_reg_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       host_wr_en;
  logic [7:0] host_addr;
  logic [7:0] host_data;
  logic       ovf_clr;
  logic       host_overflow;
  logic [2:0] fifo_count;
  logic       int_req;
  logic       int_we;
  logic [7:0] int_addr;
  logic [7:0] int_wdata;
  logic       int_gnt;
  logic       int_rvalid;
  logic [7:0] int_rdata;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'hEE;

  int checks   = 0;
  int failures = 0;

  logic [18:0] exp_q [$];
  logic [7:0]  rd_q  [$];

  always #5 clk = ~clk;

  led_reg_arbiter #(
    .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4), .MAX_GRANT(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_data(host_data),
    .ovf_clr(ovf_clr), .host_overflow(host_overflow), .fifo_count(fifo_count),
    .int_req(int_req), .int_we(int_we), .int_addr(int_addr), .int_wdata(int_wdata),
    .int_gnt(int_gnt), .int_rvalid(int_rvalid), .int_rdata(int_rdata),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata)
  );

  // Register file: data is valid only in the cycle after reg_re, garbage otherwise.
  always @(posedge clk) begin
    if (reg_re === 1'b1) reg_rdata <= (reg_addr == 8'h02) ? 8'h3C : (reg_addr ^ 8'h5A);
    else reg_rdata <= 8'hEE;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic hw, input logic [7:0] ha, input logic [7:0] hd,
                               input logic ir, input logic iw, input logic [7:0] ia,
                               input logic [7:0] iwd, input logic en, input logic oc);
    @(posedge clk);
    #1;
    host_wr_en = hw;
    host_addr  = ha;
    host_data  = hd;
    int_req    = ir;
    int_we     = iw;
    int_addr   = ia;
    int_wdata  = iwd;
    enable     = en;
    ovf_clr    = oc;
  endtask

  task automatic idleCycles(input int n, input logic en);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, en, 1'b0);
  endtask

  function automatic void pushHost(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, 1'b1, 1'b0, a, d});
  endfunction

  function automatic void pushInt(input logic we, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, we, ~we, a, d});
  endfunction

  // Every bus transaction and every read return is matched against the queues.
  always @(negedge clk) begin
    if (reg_we === 1'b1 || reg_re === 1'b1 || int_gnt === 1'b1) begin
      if (exp_q.size() == 0)
        checkOutput("unexpected_txn", {13'd0, int_gnt, reg_we, reg_re, reg_addr, reg_wdata}, 32'd0);
      else
        checkOutput("bus_txn", {13'd0, int_gnt, reg_we, reg_re, reg_addr, reg_wdata},
                    {13'd0, exp_q.pop_front()});
    end
    if (int_rvalid === 1'b1) begin
      checkOutput("rvalid_no_grant", {31'd0, int_gnt}, 32'd0);
      if (rd_q.size() == 0) checkOutput("unexpected_rvalid", {31'd0, int_rvalid}, 32'd0);
      else checkOutput("int_rdata", {24'd0, int_rdata}, {24'd0, rd_q.pop_front()});
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; host_wr_en = 1'b0; host_addr = 8'h00; host_data = 8'h00;
    ovf_clr = 1'b0; int_req = 1'b0; int_we = 1'b0; int_addr = 8'h00; int_wdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_strobes", {28'd0, reg_we, reg_re, int_gnt, int_rvalid}, 32'd0);
    checkOutput("rst_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("rst_ovf", {31'd0, host_overflow}, 32'd0);
    checkOutput("rst_bus", {8'd0, reg_addr, reg_wdata, int_rdata}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single host write: strobe exactly two cycles after the pulse.
    applyStimulus(1'b1, 8'h06, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    pushHost(8'h06, 8'h55);
    @(negedge clk) checkOutput("t1_we_n0", {31'd0, reg_we}, 32'd0);
    idleCycles(1, 1'b1);
    @(negedge clk);
    checkOutput("t1_we_n1", {31'd0, reg_we}, 32'd0);
    checkOutput("t1_count_n1", {29'd0, fifo_count}, 32'd1);
    idleCycles(1, 1'b1);
    @(negedge clk) checkOutput("t1_we_n2", {31'd0, reg_we}, 32'd1);
    idleCycles(1, 1'b1);
    @(negedge clk);
    checkOutput("t1_we_n3", {31'd0, reg_we}, 32'd0);
    checkOutput("t1_addr_hold", {24'd0, reg_addr}, 32'h06);

    // Fairness: four host grants, then the held internal write, then the rest.
    for (int i = 0; i < 4; i++) pushHost(8'h20 + 8'(i), 8'hB0 + 8'(i));
    pushInt(1'b1, 8'h10, 8'hAA);
    for (int i = 4; i < 6; i++) pushHost(8'h20 + 8'(i), 8'hB0 + 8'(i));
    for (int i = 0; i < 8; i++)
      applyStimulus(i < 6, 8'h20 + 8'(i), 8'hB0 + 8'(i), (i >= 1 && i <= 6), 1'b1,
                    8'h10, 8'hAA, 1'b1, 1'b0);
    idleCycles(4, 1'b1);

    // Overflow with grants disabled; the sixth write also pulses ovf_clr and must lose.
    for (int i = 0; i < 4; i++) pushHost(8'h30 + 8'(i), 8'hC0 + 8'(i));
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 8'h30 + 8'(i), 8'hC0 + 8'(i), 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, i == 5);
    idleCycles(1, 1'b0);
    @(negedge clk);
    checkOutput("t3_count_full", {29'd0, fifo_count}, 32'd4);
    checkOutput("t3_ovf_set", {31'd0, host_overflow}, 32'd1);
    idleCycles(8, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    idleCycles(1, 1'b1);
    @(negedge clk);
    checkOutput("t3_ovf_clr", {31'd0, host_overflow}, 32'd0);
    checkOutput("t3_count_empty", {29'd0, fifo_count}, 32'd0);

    // Full FIFO with enqueue and dequeue in the same cycle.
    for (int i = 0; i < 5; i++) pushHost(8'h40 + 8'(i), 8'hD0 + 8'(i));
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 8'h40 + 8'(i), 8'hD0 + 8'(i), 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    idleCycles(1, 1'b0);
    @(negedge clk) checkOutput("t5_count_pre", {29'd0, fifo_count}, 32'd4);
    applyStimulus(1'b1, 8'h44, 8'hD4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    idleCycles(1, 1'b1);
    @(negedge clk);
    checkOutput("t5_count_same", {29'd0, fifo_count}, 32'd4);
    checkOutput("t5_no_ovf", {31'd0, host_overflow}, 32'd0);
    idleCycles(8, 1'b1);

    // Internal read: strobe, then data one cycle after the register file answers.
    pushInt(1'b0, 8'h02, 8'h77);
    rd_q.push_back(8'h3C);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h02, 8'h77, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h02, 8'h77, 1'b1, 1'b0);
    @(negedge clk) checkOutput("t4_re", {31'd0, reg_re}, 32'd1);
    idleCycles(1, 1'b1);
    @(negedge clk) checkOutput("t4_rv_early", {31'd0, int_rvalid}, 32'd0);
    idleCycles(1, 1'b1);
    @(negedge clk) checkOutput("t4_rv", {31'd0, int_rvalid}, 32'd1);
    idleCycles(1, 1'b1);
    @(negedge clk) checkOutput("t4_rv_once", {31'd0, int_rvalid}, 32'd0);
    idleCycles(2, 1'b1);

    // Reset while waiting on read data: no return, FIFO flushed.
    pushInt(1'b0, 8'h03, 8'h00);
    applyStimulus(1'b1, 8'h50, 8'hE0, 1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk) checkOutput("t6_count_pre", {29'd0, fifo_count}, 32'd1);
    idleCycles(1, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_strobes", {28'd0, reg_we, reg_re, int_gnt, int_rvalid}, 32'd0);
    checkOutput("t6_count", {29'd0, fifo_count}, 32'd0);
    idleCycles(6, 1'b1);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && rd_q.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("sb_txn_left", exp_q.size(), 32'd0);
    checkOutput("sb_rd_left", rd_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
